// File: rtl/ssd_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit seven-segment display.
// Each digit slot is a blanking interval followed by a dwell interval; all pins are registered.
module ssd_scan_ctrl #(
   parameter int NUM_DIGITS = 8,
   parameter int DWELL      = 100000,
   parameter int BLANK      = 1000
) (
   input  logic                          ssd_scan_ctrl_port_clk,
   input  logic                          ssd_scan_ctrl_port_rst,
   input  logic                          ssd_scan_ctrl_port_en,
   input  logic [4*NUM_DIGITS-1:0]       ssd_scan_ctrl_port_digits,
   input  logic [NUM_DIGITS-1:0]         ssd_scan_ctrl_port_mask,
   input  logic                          ssd_scan_ctrl_port_lz_en,
   output logic [6:0]                    ssd_scan_ctrl_port_ssd,
   output logic [NUM_DIGITS-1:0]         ssd_scan_ctrl_port_an,
   output logic [$clog2(NUM_DIGITS)-1:0] ssd_scan_ctrl_port_cur,
   output logic                          ssd_scan_ctrl_port_frame_done
);

   localparam int IW   = $clog2(NUM_DIGITS);
   localparam int MAXV = (DWELL > BLANK) ? DWELL : BLANK;
   localparam int CW   = $clog2(MAXV + 1);

   localparam logic [CW-1:0] DWELL_LD = CW'(DWELL - 1);
   localparam logic [CW-1:0] BLANK_LD = (BLANK > 0) ? CW'(BLANK - 1) : CW'(0);
   localparam logic [IW-1:0] LAST     = IW'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {StIdle, StBlank, StShow} state_t;

   state_t          st_q, st_d;
   logic [IW-1:0]   cur_q, cur_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [3:0]      dig_q, dig_d;
   logic            blk_q, blk_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic [6:0]      ssd_q, ssd_d;
   logic            fd_q, fd_d;
   logic            load;
   logic [3:0]      dig_sel;
   logic            mask_sel;
   logic            upper_nz;
   logic            blank_new;

   function automatic logic [6:0] decode(input logic [3:0] v);
      logic [6:0] s;
      unique case (v)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   always_comb begin
      st_d  = st_q;
      cur_d = cur_q;
      cnt_d = cnt_q;
      load  = 1'b0;
      if (!ssd_scan_ctrl_port_en) begin
         st_d  = StIdle;
         cur_d = '0;
         cnt_d = '0;
      end else begin
         unique case (st_q)
            StIdle: begin
               cur_d = '0;
               if (BLANK > 0) begin
                  st_d  = StBlank;
                  cnt_d = BLANK_LD;
               end else begin
                  st_d  = StShow;
                  cnt_d = DWELL_LD;
                  load  = 1'b1;
               end
            end
            StBlank: begin
               if (cnt_q == '0) begin
                  st_d  = StShow;
                  cnt_d = DWELL_LD;
                  load  = 1'b1;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            StShow: begin
               if (cnt_q == '0) begin
                  cur_d = (cur_q == LAST) ? '0 : cur_q + 1'b1;
                  if (BLANK > 0) begin
                     st_d  = StBlank;
                     cnt_d = BLANK_LD;
                  end else begin
                     st_d  = StShow;
                     cnt_d = DWELL_LD;
                     load  = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            default: st_d = StIdle;
         endcase
      end
   end

   // Digit value and blank flag for the slot being entered; captured only on SHOW entry.
   always_comb begin
      dig_sel  = '0;
      mask_sel = 1'b0;
      upper_nz = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (IW'(i) == cur_d) begin
            dig_sel  = ssd_scan_ctrl_port_digits[4*i +: 4];
            mask_sel = ssd_scan_ctrl_port_mask[i];
         end
         if (IW'(i) >= cur_d && ssd_scan_ctrl_port_digits[4*i +: 4] != 4'h0) upper_nz = 1'b1;
      end
      blank_new = !mask_sel || (ssd_scan_ctrl_port_lz_en && cur_d != '0 && !upper_nz);
   end

   always_comb begin
      dig_d = load ? dig_sel : dig_q;
      blk_d = load ? blank_new : blk_q;
      an_d  = '1;
      ssd_d = 7'h7F;
      if (st_d == StShow && !blk_d) begin
         for (int i = 0; i < NUM_DIGITS; i++) an_d[i] = (IW'(i) != cur_d);
         ssd_d = decode(dig_d);
      end
      fd_d = (st_d == StShow) && (cur_d == LAST) && (cnt_d == '0);
   end

   always_ff @(posedge ssd_scan_ctrl_port_clk or negedge ssd_scan_ctrl_port_rst) begin
      if (!ssd_scan_ctrl_port_rst) begin
         st_q  <= StIdle;
         cur_q <= '0;
         cnt_q <= '0;
         dig_q <= '0;
         blk_q <= 1'b1;
         an_q  <= '1;
         ssd_q <= 7'h7F;
         fd_q  <= 1'b0;
      end else begin
         st_q  <= st_d;
         cur_q <= cur_d;
         cnt_q <= cnt_d;
         dig_q <= dig_d;
         blk_q <= blk_d;
         an_q  <= an_d;
         ssd_q <= ssd_d;
         fd_q  <= fd_d;
      end
   end

   assign ssd_scan_ctrl_port_ssd        = ssd_q;
   assign ssd_scan_ctrl_port_an         = an_q;
   assign ssd_scan_ctrl_port_cur        = cur_q;
   assign ssd_scan_ctrl_port_frame_done = fd_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Scoreboard bench for ssd_scan_ctrl: two instances (BLANK=2 and BLANK=0) driven by shared
// randomized inputs, checked cycle by cycle against a slot-arithmetic reference model.
module tb_ssd_scan_ctrl;

   localparam int N  = 8;
   localparam int D  = 4;
   localparam int BA = 2;
   localparam int BB = 0;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        lz_en = 1'b0;
   logic [31:0] digits = 32'h0;
   logic [7:0]  mask = 8'hFF;

   logic [6:0] ssd_a, ssd_b;
   logic [7:0] an_a, an_b;
   logic [2:0] cur_a, cur_b;
   logic       fd_a, fd_b;

   int total = 0;
   int bad = 0;

   typedef struct packed {
      logic [7:0] an;
      logic [6:0] ssd;
      logic [2:0] cur;
      logic       fd;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];

   logic [6:0] seg_tab [16];
   int         m_act [2];
   int         m_k [2];
   logic [6:0] m_seg [2];
   logic       m_blank [2];

   ssd_scan_ctrl #(.NUM_DIGITS(N), .DWELL(D), .BLANK(BA)) dut_a (
      .ssd_scan_ctrl_port_clk       (clk),
      .ssd_scan_ctrl_port_rst       (rst_n),
      .ssd_scan_ctrl_port_en        (en),
      .ssd_scan_ctrl_port_digits    (digits),
      .ssd_scan_ctrl_port_mask      (mask),
      .ssd_scan_ctrl_port_lz_en     (lz_en),
      .ssd_scan_ctrl_port_ssd       (ssd_a),
      .ssd_scan_ctrl_port_an        (an_a),
      .ssd_scan_ctrl_port_cur       (cur_a),
      .ssd_scan_ctrl_port_frame_done(fd_a)
   );

   ssd_scan_ctrl #(.NUM_DIGITS(N), .DWELL(D), .BLANK(BB)) dut_b (
      .ssd_scan_ctrl_port_clk       (clk),
      .ssd_scan_ctrl_port_rst       (rst_n),
      .ssd_scan_ctrl_port_en        (en),
      .ssd_scan_ctrl_port_digits    (digits),
      .ssd_scan_ctrl_port_mask      (mask),
      .ssd_scan_ctrl_port_lz_en     (lz_en),
      .ssd_scan_ctrl_port_ssd       (ssd_b),
      .ssd_scan_ctrl_port_an        (an_b),
      .ssd_scan_ctrl_port_cur       (cur_b),
      .ssd_scan_ctrl_port_frame_done(fd_b)
   );

   always #5 clk = ~clk;

   // Expected pins for the cycle after the next rising edge, from the inputs now on the bus.
   task automatic model_step(input int i, input int b, output exp_t e);
      int   p, slot, pos;
      logic up0;
      e.an  = 8'hFF;
      e.ssd = 7'h7F;
      e.cur = 3'd0;
      e.fd  = 1'b0;
      if (!en) begin
         m_act[i] = 0;
         return;
      end
      if (m_act[i] == 0) begin
         m_act[i] = 1;
         m_k[i]   = 0;
      end else begin
         m_k[i]++;
      end
      p    = b + D;
      slot = (m_k[i] / p) % N;
      pos  = m_k[i] % p;
      if (pos == b) begin
         up0 = 1'b1;
         for (int j = slot; j < N; j++) if (digits[4*j +: 4] != 4'h0) up0 = 1'b0;
         m_blank[i] = !mask[slot] || (lz_en && slot != 0 && up0);
         m_seg[i]   = seg_tab[digits[4*slot +: 4]];
      end
      e.cur = 3'(slot);
      if (pos >= b && !m_blank[i]) begin
         e.an  = ~(8'd1 << slot);
         e.ssd = m_seg[i];
      end
      e.fd = (slot == N - 1) && (pos == p - 1);
   endtask

   task automatic push_both();
      exp_t e;
      model_step(0, BA, e);
      q_a.push_back(e);
      model_step(1, BB, e);
      q_b.push_back(e);
   endtask

   task automatic check(input string tag, input exp_t e, input logic [7:0] an,
                        input logic [6:0] ssd, input logic [2:0] cur, input logic fd);
      total += 4;
      if (an !== e.an) begin
         bad++;
         $display("FAIL %s an @%0t: got %h want %h", tag, $time, an, e.an);
      end
      if (ssd !== e.ssd) begin
         bad++;
         $display("FAIL %s ssd @%0t: got %h want %h", tag, $time, ssd, e.ssd);
      end
      if (cur !== e.cur) begin
         bad++;
         $display("FAIL %s cur @%0t: got %0d want %0d", tag, $time, cur, e.cur);
      end
      if (fd !== e.fd) begin
         bad++;
         $display("FAIL %s frame_done @%0t: got %b want %b", tag, $time, fd, e.fd);
      end
   endtask

   task automatic check_dark(input string tag);
      exp_t e;
      e.an  = 8'hFF;
      e.ssd = 7'h7F;
      e.cur = 3'd0;
      e.fd  = 1'b0;
      check({tag, "_a"}, e, an_a, ssd_a, cur_a, fd_a);
      check({tag, "_b"}, e, an_b, ssd_b, cur_b, fd_b);
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (q_a.size() > 0) begin
         e = q_a.pop_front();
         check("a", e, an_a, ssd_a, cur_a, fd_a);
      end
      if (q_b.size() > 0) begin
         e = q_b.pop_front();
         check("b", e, an_b, ssd_b, cur_b, fd_b);
      end
   end

   function automatic logic [31:0] pick_digits();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 3))
         0:       return r;
         1:       return r >> (4 * $urandom_range(1, 7));
         2:       return 32'h00000305;
         default: return 32'h0;
      endcase
   endfunction

   initial begin
      seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      m_act   = '{0, 0};
      m_k     = '{0, 0};
      m_blank = '{1'b1, 1'b1};
      m_seg   = '{7'h7F, 7'h7F};

      repeat (3) @(negedge clk);
      check_dark("reset");
      rst_n  = 1'b1;
      en     = 1'b1;
      digits = 32'h76543210;
      mask   = 8'hFF;
      lz_en  = 1'b0;
      push_both();

      for (int cyc = 1; cyc < 6000; cyc++) begin
         @(negedge clk);
         if (cyc == 200) begin
            digits = 32'h00000305;
            lz_en  = 1'b1;
         end else if (cyc == 400) begin
            digits = 32'h0;
            mask   = 8'h0F;
            lz_en  = 1'b0;
         end else if (cyc >= 600) begin
            if ($urandom_range(0, 39) == 0) digits = pick_digits();
            if ($urandom_range(0, 59) == 0) begin
               case ($urandom_range(0, 2))
                  0:       mask = 8'hFF;
                  1:       mask = 8'h0F;
                  default: mask = 8'($urandom);
               endcase
            end
            if ($urandom_range(0, 49) == 0) lz_en = ~lz_en;
            if (en) begin
               if ($urandom_range(0, 299) == 0) en = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
               en = 1'b1;
            end
         end

         if (cyc == 3000 || cyc == 4517) begin
            // Asynchronous reset between clock edges: pins go dark before any edge arrives.
            #2 rst_n = 1'b0;
            #1 check_dark("async_rst");
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            m_act = '{0, 0};
         end
         push_both();
      end

      @(posedge clk);
      #2;
      total++;
      if (q_a.size() != 0 || q_b.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d/%0d left want 0", q_a.size(), q_b.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
